alu_uart_sequencer: RTL

Upstream command stage for the registered ALU datapath. It takes bytes from the UART receiver and assembles them into an operand-A / operand-B / opcode frame. It drives the A, B and OP inputs of the combinational ALU core, captures the result and flags, and returns two response bytes (result, then flags) through the UART transmitter. Within a frame it also validates opcodes and enforces a byte-gap timeout so a dropped byte cannot desynchronise the stream.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_uart_sequencer_if.sv | 20 ++
 rtl/alu_uart_sequencer_gap_timer.sv | 26 ++
 rtl/alu_uart_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, ALU opcode set and sequencer state encoding for the
// UART-driven ALU command stage.
package alu_pkg;

  localparam int unsigned NB_DATA = 8;
  localparam int unsigned NB_OP   = 6;

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_B,
    ST_GET_OP,
    ST_CAPTURE,
    ST_TX_RES,
    ST_TX_FLG
  } state_t;

  function automatic logic is_valid_op(input logic [NB_OP-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_uart_sequencer_if.sv
// UART byte handshake between the sequencer (master) and the UART RX/TX pair (slave).
interface alu_uart_sequencer_if #(
  parameter int unsigned NB_DATA = alu_pkg::NB_DATA
);
  logic [NB_DATA-1:0] rx_data;
  logic               rx_done;
  logic               tx_done;
  logic               tx_start;
  logic [NB_DATA-1:0] tx_data;

  modport master (
    input  rx_data, rx_done, tx_done,
    output tx_start, tx_data
  );

  modport slave (
    output rx_data, rx_done, tx_done,
    input  tx_start, tx_data
  );
endinterface

// File: rtl/alu_uart_sequencer_gap_timer.sv
// Inter-byte gap counter: cleared per accepted byte, counts while enabled,
// flags expiry once it has sat at TIMEOUT_CYCLES-1.
module gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int unsigned NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

  logic [NB_CNT-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt <= '0;
    end else if (i_en && (cnt != LAST)) begin
      cnt <= cnt + NB_CNT'(1);
    end
  end

  assign o_expired = i_en && (cnt == LAST);
endmodule

// File: rtl/alu_uart_sequencer.sv
// Assembles A/B/OP frames from UART RX bytes, drives the ALU operand registers
// and returns result and flags bytes through UART TX.
module alu_uart_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA        = alu_pkg::NB_DATA,
  parameter int unsigned NB_OP          = alu_pkg::NB_OP,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  alu_uart_sequencer_if.master uart,
  output logic [NB_DATA-1:0]   o_data_a,
  output logic [NB_DATA-1:0]   o_data_b,
  output logic [NB_OP-1:0]     o_op,
  input  logic [NB_DATA-1:0]   i_alu_result,
  input  logic                 i_alu_zero,
  input  logic                 i_alu_overflow,
  output logic                 o_busy,
  output logic                 o_error
);
  state_t             state;
  logic [NB_DATA-1:0] flags;
  logic               byte_taken;
  logic               gap_en;
  logic               gap_expired;
  logic               opcode_ok;

  assign byte_taken = uart.rx_done &&
                      (state == ST_IDLE || state == ST_GET_B || state == ST_GET_OP);
  assign gap_en     = (state == ST_GET_B) || (state == ST_GET_OP);
  assign opcode_ok  = (uart.rx_data[NB_DATA-1:NB_OP] == '0) &&
                      is_valid_op(uart.rx_data[NB_OP-1:0]);

  gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (byte_taken),
    .i_en      (gap_en),
    .o_expired (gap_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      o_data_a      <= '0;
      o_data_b      <= '0;
      o_op          <= '0;
      flags         <= '0;
      uart.tx_data  <= '0;
      uart.tx_start <= 1'b0;
      o_busy        <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      uart.tx_start <= 1'b0;
      o_error       <= 1'b0;
      case (state)
        ST_IDLE: if (uart.rx_done) begin
          o_data_a <= uart.rx_data;
          state    <= ST_GET_B;
          o_busy   <= 1'b1;
        end
        // A byte landing on the expiry cycle takes priority over the timeout.
        ST_GET_B: if (uart.rx_done) begin
          o_data_b <= uart.rx_data;
          state    <= ST_GET_OP;
        end else if (gap_expired) begin
          o_error <= 1'b1;
          state   <= ST_IDLE;
          o_busy  <= 1'b0;
        end
        ST_GET_OP: if (uart.rx_done) begin
          if (opcode_ok) begin
            o_op  <= uart.rx_data[NB_OP-1:0];
            state <= ST_CAPTURE;
          end else begin
            o_error <= 1'b1;
            state   <= ST_IDLE;
            o_busy  <= 1'b0;
          end
        end else if (gap_expired) begin
          o_error <= 1'b1;
          state   <= ST_IDLE;
          o_busy  <= 1'b0;
        end
        ST_CAPTURE: begin
          uart.tx_data  <= i_alu_result;
          flags         <= NB_DATA'({i_alu_overflow, i_alu_zero});
          uart.tx_start <= 1'b1;
          state         <= ST_TX_RES;
        end
        // Ignoring tx_done while tx_start is still high keeps starts non-adjacent.
        ST_TX_RES: if (uart.tx_done && !uart.tx_start) begin
          uart.tx_data  <= flags;
          uart.tx_start <= 1'b1;
          state         <= ST_TX_FLG;
        end
        ST_TX_FLG: if (uart.tx_done) begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
